// File: rtl/down_wrap_timer_pkg.sv
// down_wrap_timer_pkg: shared widths and state encoding for the wrap timer
package down_wrap_timer_pkg;
  localparam int CNT_W = 4;
  localparam int WRAP_W = 8;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
endpackage

// File: rtl/down_wrap_timer_wrap_detect.sv
// wrap_detect: flags a 0 -> all-ones transition of a cascaded down counter
module wrap_detect #(
  parameter int CNT_W = down_wrap_timer_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             set,
  input  logic [CNT_W-1:0] cnt_in,
  output logic             wrap_det
);
  logic [CNT_W-1:0] prev_q;
  logic             prev_valid;
  // remember last counter value; prev_valid blocks detection right after reset
  always_ff @(posedge clk) begin
    prev_q     <= set ? '0 : cnt_in;
    prev_valid <= !set;
  end
  assign wrap_det = prev_valid && prev_q == '0 && cnt_in == '1;
endmodule

// File: rtl/down_wrap_timer.sv
// down_wrap_timer: counts upstream counter wraps down from a loaded value
module down_wrap_timer #(
  parameter int CNT_W = down_wrap_timer_pkg::CNT_W,
  parameter int WRAP_W = down_wrap_timer_pkg::WRAP_W
) (
  input  logic              clk,
  input  logic              set,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              en,
  input  logic              load,
  input  logic [WRAP_W-1:0] load_val,
  input  logic              auto_reload,
  output logic [WRAP_W-1:0] remaining,
  output logic              wrap_pulse,
  output logic              done,
  output logic              busy
);
  import down_wrap_timer_pkg::*;
  state_t            state, state_n;
  logic [WRAP_W-1:0] reload_q, rem_n, reload_n;
  logic              done_n, wrap_det;
  wrap_detect #(.CNT_W(CNT_W)) u_det (
    .clk(clk),
    .set(set),
    .cnt_in(cnt_in),
    .wrap_det(wrap_det)
  );
  // state, counter and pulse registers
  always_ff @(posedge clk) begin
    if (set) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      reload_q   <= '0;
      done       <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      remaining  <= rem_n;
      reload_q   <= reload_n;
      done       <= done_n;
      wrap_pulse <= wrap_det;
    end
  end
  // load has priority over a coincident wrap; only the last wrap expires
  always_comb begin
    state_n  = state;
    rem_n    = remaining;
    reload_n = reload_q;
    done_n   = 1'b0;
    if (load) begin
      if (load_val != '0) begin
        rem_n    = load_val;
        reload_n = load_val;
        state_n  = ST_RUN;
      end else if (state == ST_RUN) begin
        rem_n   = '0;
        state_n = ST_IDLE;
      end
    end else if (state == ST_RUN && wrap_det && en) begin
      if (remaining > WRAP_W'(1)) begin
        rem_n = remaining - WRAP_W'(1);
      end else begin
        done_n  = 1'b1;
        rem_n   = auto_reload ? reload_q : '0;
        state_n = auto_reload ? ST_RUN : ST_DONE;
      end
    end
  end
  assign busy = state == ST_RUN;
endmodule

// File: tb/tb_down_wrap_timer.sv
// tb_down_wrap_timer: directed vectors plus free-running counter sequences
module tb_down_wrap_timer;
  logic       clk = 1'b0;
  logic       set, en, load, auto_reload;
  logic [3:0] cnt_in;
  logic [7:0] load_val, remaining;
  logic       wrap_pulse, done, busy;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       set;
    logic [3:0] cnt;
    logic       en;
    logic       load;
    logic [7:0] lv;
    logic       ar;
    logic [7:0] rem;
    logic       wp;
    logic       dn;
    logic       bz;
  } vec_t;
  vec_t vq[$];

  down_wrap_timer dut (
    .clk(clk),
    .set(set),
    .cnt_in(cnt_in),
    .en(en),
    .load(load),
    .load_val(load_val),
    .auto_reload(auto_reload),
    .remaining(remaining),
    .wrap_pulse(wrap_pulse),
    .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic add(input logic s, input logic [3:0] c, input logic e, input logic l,
                     input logic [7:0] v, input logic a, input logic [7:0] r,
                     input logic w, input logic d, input logic b);
    vec_t t;
    t.set = s; t.cnt = c; t.en = e; t.load = l; t.lv = v; t.ar = a;
    t.rem = r; t.wp = w; t.dn = d; t.bz = b;
    vq.push_back(t);
  endtask

  logic [3:0] c, last;
  logic [7:0] m_rem, m_rel;
  logic       m_busy, m_done, m_wp;
  int         dcount;

  task automatic cyc(input logic ld, input logic [7:0] lv, input logic ar, input string tag);
    set = 1'b0; en = 1'b1; load = ld; load_val = lv; auto_reload = ar; cnt_in = c;
    m_wp = last == 4'h0 && c == 4'hF;
    m_done = 1'b0;
    if (ld && lv != 0) begin
      m_rem = lv; m_rel = lv; m_busy = 1'b1;
    end else if (ld && m_busy) begin
      m_rem = 0; m_busy = 1'b0;
    end else if (m_busy && m_wp) begin
      if (m_rem > 1) m_rem = m_rem - 1;
      else begin
        m_done = 1'b1;
        if (ar) m_rem = m_rel;
        else begin m_rem = 0; m_busy = 1'b0; end
      end
    end
    tick();
    check({tag, " rem"}, remaining, m_rem);
    check({tag, " wrap_pulse"}, wrap_pulse, m_wp);
    check({tag, " done"}, done, m_done);
    check({tag, " busy"}, busy, m_busy);
    if (done) dcount++;
    last = c;
    c = c - 4'd1;
  endtask

  initial begin
    //   set cnt  en load lv ar | rem wp dn bz
    add(1, 4'hF, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 4'hF, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'hF, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'h5, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'hE, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'hF, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 4'hF, 1, 0, 0, 0, 0, 1, 0, 0);
    add(0, 4'h0, 1, 1, 3, 0, 3, 0, 0, 1);
    add(0, 4'hF, 1, 0, 0, 0, 2, 1, 0, 1);
    add(0, 4'h0, 0, 0, 0, 0, 2, 0, 0, 1);
    add(0, 4'hF, 0, 0, 0, 0, 2, 1, 0, 1);
    add(0, 4'h0, 1, 0, 0, 0, 2, 0, 0, 1);
    add(0, 4'hF, 1, 1, 5, 0, 5, 1, 0, 1);
    add(0, 4'h0, 1, 0, 0, 0, 5, 0, 0, 1);
    add(0, 4'hF, 1, 0, 0, 0, 4, 1, 0, 1);
    add(0, 4'h0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 4'hF, 1, 0, 0, 0, 0, 1, 0, 0);
    add(0, 4'h0, 1, 1, 1, 0, 1, 0, 0, 1);
    add(0, 4'hF, 1, 0, 0, 0, 0, 1, 1, 0);
    add(0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'hF, 1, 0, 0, 0, 0, 1, 0, 0);
    add(0, 4'h0, 1, 1, 4, 0, 4, 0, 0, 1);
    add(1, 4'h5, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'hF, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0);
    foreach (vq[i]) begin
      set = vq[i].set; cnt_in = vq[i].cnt; en = vq[i].en; load = vq[i].load;
      load_val = vq[i].lv; auto_reload = vq[i].ar;
      tick();
      check($sformatf("v%0d rem", i), remaining, vq[i].rem);
      check($sformatf("v%0d wrap_pulse", i), wrap_pulse, vq[i].wp);
      check($sformatf("v%0d done", i), done, vq[i].dn);
      check($sformatf("v%0d busy", i), busy, vq[i].bz);
    end
    last = 4'h0; c = 4'hA; m_rem = 0; m_rel = 0; m_busy = 1'b0;
    cyc(1, 8'd3, 0, "basic load");
    dcount = 0;
    for (int i = 0; i < 130; i++) cyc(0, 8'd0, 0, "basic run");
    check("basic done count", dcount, 1);
    check("basic final busy", busy, 0);
    cyc(1, 8'd2, 1, "auto load");
    dcount = 0;
    for (int i = 0; i < 80; i++) cyc(0, 8'd0, 1, "auto run");
    check("auto done count", dcount, 2);
    check("auto busy", busy, 1);
    dcount = 0;
    for (int i = 0; i < 40; i++) cyc(0, 8'd0, 0, "auto stop");
    check("stop done count", dcount, 1);
    check("stop busy", busy, 0);
    check("stop rem", remaining, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
